// File: rtl/keyb_debounce_multi.sv
// Multi-channel key debouncer with per-channel sync/debounce and a prioritised press-event port.
// Define KEYB_AUTOREPEAT_EN to build the per-channel auto-repeat counters.
module keyb_debounce_multi #(
   parameter int CHANNELS             = 16,
   parameter int DEBOUNCE_CYCLES      = 50000,
   parameter int REPEAT_DELAY_CYCLES  = 25000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000,
   parameter int IDX_W                = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [CHANNELS-1:0] key_raw_i,
   output logic [CHANNELS-1:0] key_stable_o,
   output logic [CHANNELS-1:0] press_pulse_o,
   output logic [CHANNELS-1:0] release_pulse_o,
   output logic                event_valid_o,
   output logic [IDX_W-1:0]    event_idx_o,
   input  logic                event_ack_i,
   output logic                event_overrun_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] syncFirst_q;
   logic [CHANNELS-1:0] syncSecond_q;
   logic [CHANNELS-1:0] stable_q;
   logic [CHANNELS-1:0] stable_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] repeatFire;
   logic [CHANNELS-1:0] press_d;
   logic [CHANNELS-1:0] press_q;
   logic [CHANNELS-1:0] release_d;
   logic [CHANNELS-1:0] release_q;
   logic [CHANNELS-1:0] pending_q;
   logic [CHANNELS-1:0] pending_d;
   logic [CHANNELS-1:0] lowestOneHot;
   logic [CHANNELS-1:0] ackMask;
   logic [IDX_W-1:0]    lowestIdx;
   logic                anyPending;
   logic                overrun_d;
   logic                overrun_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         syncFirst_q  <= '0;
         syncSecond_q <= '0;
      end else begin
         syncFirst_q  <= key_raw_i;
         syncSecond_q <= syncFirst_q;
      end
   end

   // A level change is accepted once the synchronised input has disagreed for DEBOUNCE_CYCLES edges.
   always_comb begin
      accept   = '0;
      stable_d = stable_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         if (syncSecond_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               accept[i]   = 1'b1;
               stable_d[i] = syncSecond_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stable_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef KEYB_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int REP_W = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);

   logic [REP_W-1:0]    repCnt_q [CHANNELS];
   logic [REP_W-1:0]    repCnt_d [CHANNELS];
   logic [CHANNELS-1:0] repArmed_q;
   logic [CHANNELS-1:0] repArmed_d;

   // repArmed marks that the initial delay has elapsed, so later repeats use the period.
   always_comb begin
      repeatFire = '0;
      repArmed_d = repArmed_q;
      for (int i = 0; i < CHANNELS; i++) begin
         repCnt_d[i] = '0;
         if (!stable_q[i] || accept[i]) begin
            repArmed_d[i] = 1'b0;
         end else if (repCnt_q[i] == (repArmed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
            repeatFire[i] = 1'b1;
            repArmed_d[i] = 1'b1;
         end else begin
            repCnt_d[i] = repCnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         repArmed_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            repCnt_q[i] <= '0;
         end
      end else begin
         repArmed_q <= repArmed_d;
         for (int i = 0; i < CHANNELS; i++) begin
            repCnt_q[i] <= repCnt_d[i];
         end
      end
   end
`else
   // Repeat timing has no effect when auto-repeat is not built.
   localparam bit REPEAT_CFG = (REPEAT_DELAY_CYCLES > 0) || (REPEAT_PERIOD_CYCLES > 0);
   assign repeatFire = {CHANNELS{1'b0}} & {CHANNELS{REPEAT_CFG}};
`endif

   assign press_d   = (accept & syncSecond_q) | repeatFire;
   assign release_d = accept & ~syncSecond_q;

   always_comb begin
      lowestIdx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowestIdx = IDX_W'(i);
         end
      end
   end

   // A new press on the acked bit wins over the ack, so it is OR-ed in after clearing.
   assign anyPending   = |pending_q;
   assign lowestOneHot = pending_q & (~pending_q + 1'b1);
   assign ackMask      = (anyPending && event_ack_i) ? lowestOneHot : '0;
   assign pending_d    = (pending_q & ~ackMask) | press_d;
   assign overrun_d    = |(press_d & pending_q & ~ackMask);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         press_q   <= '0;
         release_q <= '0;
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         press_q   <= press_d;
         release_q <= release_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign key_stable_o    = stable_q;
   assign press_pulse_o   = press_q;
   assign release_pulse_o = release_q;
   assign event_valid_o   = anyPending;
   assign event_idx_o     = lowestIdx;
   assign event_overrun_o = overrun_q;

endmodule

// File: tb/tb_keyb_debounce_multi.sv
// Randomised + directed scoreboard bench for keyb_debounce_multi (4 channels, 8-cycle debounce).
// Honours KEYB_AUTOREPEAT_EN in its reference model the same way the design does.
module tb_keyb_debounce_multi;

   localparam int CH = 4;
   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 10;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rstN;
   logic [CH-1:0] keyRaw;
   logic          eventAck;
   logic [CH-1:0] keyStable;
   logic [CH-1:0] pressPulse;
   logic [CH-1:0] releasePulse;
   logic          eventValid;
   logic [IW-1:0] eventIdx;
   logic          eventOverrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [CH-1:0] stable;
      logic [CH-1:0] press;
      logic [CH-1:0] rel;
      logic          valid;
      logic [IW-1:0] idx;
      logic          overrun;
   } exp_t;

   exp_t expQ[$];

   keyb_debounce_multi #(
      .CHANNELS(CH),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY_CYCLES(RD),
      .REPEAT_PERIOD_CYCLES(RP),
      .IDX_W(IW)
   ) dut (
      .clk_i(clk),
      .reset_n_i(rstN),
      .key_raw_i(keyRaw),
      .key_stable_o(keyStable),
      .press_pulse_o(pressPulse),
      .release_pulse_o(releasePulse),
      .event_valid_o(eventValid),
      .event_idx_o(eventIdx),
      .event_ack_i(eventAck),
      .event_overrun_o(eventOverrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   function automatic logic [IW-1:0] lowestOf(input logic [CH-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (v[i]) r = IW'(i);
      end
      return r;
   endfunction

   // Reference model: a level is accepted when the last DB synchronised samples all disagree
   // with the current debounced level; pending events are a plain bit set served lowest first.
   logic [CH-1:0] mSync1, mSync2, mStable, mPend;
   logic [CH-1:0] syncHist[$];
   logic [CH-1:0] flipV, pressV, relV, ackBit;
   int            pressEdge[CH];
   int            edgeNum = 0;
   int            held;
   exp_t          modE;

   always @(posedge clk) begin
      edgeNum++;
      if (!rstN) begin
         mSync1 = '0; mSync2 = '0; mStable = '0; mPend = '0;
         syncHist.delete();
         modE.stable = '0; modE.press = '0; modE.rel = '0;
         modE.valid = 1'b0; modE.idx = '0; modE.overrun = 1'b0;
      end else begin
         flipV = '0; pressV = '0; relV = '0;
         syncHist.push_back(mSync2);
         if (syncHist.size() > DB) void'(syncHist.pop_front());
         for (int c = 0; c < CH; c++) begin
            flipV[c] = (syncHist.size() == DB);
            for (int k = 0; k < syncHist.size(); k++) begin
               if (syncHist[k][c] == mStable[c]) flipV[c] = 1'b0;
            end
            if (flipV[c]) begin
               if (mSync2[c]) begin
                  pressV[c] = 1'b1;
                  pressEdge[c] = edgeNum;
               end else begin
                  relV[c] = 1'b1;
               end
            end
`ifdef KEYB_AUTOREPEAT_EN
            else if (mStable[c]) begin
               held = edgeNum - pressEdge[c];
               if (held == RD || (held > RD && (held - RD) % RP == 0)) pressV[c] = 1'b1;
            end
`endif
         end
         mStable = mStable ^ flipV;
         ackBit = '0;
         if (mPend != '0 && eventAck) ackBit[lowestOf(mPend)] = 1'b1;
         modE.overrun = |(pressV & mPend & ~ackBit);
         mPend = (mPend & ~ackBit) | pressV;
         mSync2 = mSync1;
         mSync1 = keyRaw;
         modE.stable = mStable; modE.press = pressV; modE.rel = relV;
         modE.valid = (mPend != '0); modE.idx = lowestOf(mPend);
      end
      expQ.push_back(modE);
   end

   exp_t monE;

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput("key_stable", 8'(keyStable), 8'(monE.stable));
         checkOutput("press_pulse", 8'(pressPulse), 8'(monE.press));
         checkOutput("release_pulse", 8'(releasePulse), 8'(monE.rel));
         checkOutput("event_valid", 8'(eventValid), 8'(monE.valid));
         checkOutput("event_overrun", 8'(eventOverrun), 8'(monE.overrun));
         if (monE.valid) checkOutput("event_idx", 8'(eventIdx), 8'(monE.idx));
      end
   end

   task automatic applyStimulus(input logic [CH-1:0] raw, input logic ack, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         #1;
         keyRaw   = raw;
         eventAck = ack;
      end
   endtask

   task automatic pulseReset(input int cycles);
      @(negedge clk);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("rst_key_stable", 8'(keyStable), 8'h00);
      checkOutput("rst_press_pulse", 8'(pressPulse), 8'h00);
      checkOutput("rst_release_pulse", 8'(releasePulse), 8'h00);
      checkOutput("rst_event_valid", 8'(eventValid), 8'h00);
      checkOutput("rst_event_overrun", 8'(eventOverrun), 8'h00);
      repeat (cycles) @(negedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      rstN     = 1'b1;
      keyRaw   = '0;
      eventAck = 1'b0;
      #1 rstN  = 1'b0;
      repeat (3) @(negedge clk);
      #1 rstN  = 1'b1;

      // Clean press on ch2, ack, release
      applyStimulus(4'b0100, 1'b0, 20);
      applyStimulus(4'b0100, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 15);

      // Bouncing press on ch0
      for (int r = 0; r < 4; r++) begin
         applyStimulus(4'b0001, 1'b0, 3);
         applyStimulus(4'b0000, 1'b0, 2);
      end
      applyStimulus(4'b0001, 1'b0, 15);
      applyStimulus(4'b0001, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 15);

      // Simultaneous ch1 + ch3
      applyStimulus(4'b1010, 1'b0, 15);
      applyStimulus(4'b1010, 1'b1, 1);
      applyStimulus(4'b1010, 1'b0, 2);
      applyStimulus(4'b1010, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 15);

      // Overrun on ch1
      applyStimulus(4'b0010, 1'b0, 12);
      applyStimulus(4'b0000, 1'b0, 12);
      applyStimulus(4'b0010, 1'b0, 12);
      applyStimulus(4'b0010, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 15);

      // Reset mid-debounce on ch0
      applyStimulus(4'b0001, 1'b0, 7);
      pulseReset(2);
      applyStimulus(4'b0001, 1'b0, 14);
      applyStimulus(4'b0001, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 15);

      // Long hold on ch2 (auto-repeat when built in)
      applyStimulus(4'b0100, 1'b0, 60);
      applyStimulus(4'b0100, 1'b1, 1);
      applyStimulus(4'b0000, 1'b0, 30);

      // Randomised keys with random acks
      for (int n = 0; n < 60; n++) begin
         logic [CH-1:0] rv;
         int hold;
         rv   = CH'($urandom_range(0, 15));
         hold = $urandom_range(1, 14);
         for (int h = 0; h < hold; h++) begin
            applyStimulus(rv, $urandom_range(0, 2) == 0, 1);
         end
      end
      applyStimulus(4'b0000, 1'b1, 20);
      applyStimulus(4'b0000, 1'b0, 3);

      checkOutput("scoreboard_drained", 8'(expQ.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
